wall_collision_scanner: RTL

//  Parametrised wall-collision checker for the game logic. Owns a wall-position table
//  (loaded serially at level start) and answers "does next position hit a wall?"

---
 rtl/wall_pkg.sv | 19 +
 rtl/wall_match_group.sv | 37 +++
 rtl/wall_collision_scanner.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/wall_pkg.sv
// Shared types and width helper for the wall-collision scanner and its match group.
package wall_pkg;

   localparam int POS_W_DEF = 8;

   typedef logic [POS_W_DEF-1:0] pos_t;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DONE
   } scan_state_e;

   // Bits needed to index n items; never less than one so single-entry configs stay legal.
   function automatic int clog2_cnt(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/wall_match_group.sv
// One scan group: LANES masked equality comparators feeding a lowest-index priority encoder.
module wall_match_group
   import wall_pkg::*;
#(
   parameter int POS_W = 8,
   parameter int LANES = 4,
   localparam int LIW  = clog2_cnt(LANES)
) (
   input  logic [POS_W-1:0]       i_key,
   input  logic [LANES*POS_W-1:0] i_entries,
   input  logic [LANES-1:0]       i_valid,
   output logic                   o_any_hit,
   output logic [LIW-1:0]         o_lane_idx
);

   logic [LANES-1:0] w_hit;

   always_comb begin
      w_hit = '0;
      for (int l = 0; l < LANES; l++) begin
         w_hit[l] = i_valid[l] && (i_entries[l*POS_W +: POS_W] == i_key);
      end
   end

   // Walk from the top lane down so the last assignment wins with the lowest lane.
   always_comb begin
      o_any_hit  = 1'b0;
      o_lane_idx = '0;
      for (int l = LANES - 1; l >= 0; l--) begin
         if (w_hit[l]) begin
            o_any_hit  = 1'b1;
            o_lane_idx = LIW'(l);
         end
      end
   end

endmodule

// File: rtl/wall_collision_scanner.sv
// Wall-position table with serial append and a LANES-wide early-exit collision query.
module wall_collision_scanner
   import wall_pkg::*;
#(
   parameter int POS_W     = 8,
   parameter int MAX_WALLS = 32,
   parameter int LANES     = 4,
   localparam int CW       = clog2_cnt(MAX_WALLS + 1),
   localparam int IW       = clog2_cnt(MAX_WALLS)
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             clear,
   input  logic             wr_en,
   input  logic [POS_W-1:0] wr_pos,
   output logic             wr_ready,
   output logic [CW-1:0]    wall_count,
   output logic             table_full,
   output logic             wr_overflow,
   input  logic             chk_req,
   input  logic [POS_W-1:0] chk_pos,
   output logic             chk_busy,
   output logic             chk_done,
   output logic             collision,
   output logic [IW-1:0]    hit_index
);

   localparam int BW   = clog2_cnt(MAX_WALLS + LANES);
   localparam int LIW  = clog2_cnt(LANES);
   localparam int CMPW = ((BW > CW) ? BW : CW) + 1;

   scan_state_e r_state, w_next;

   logic [POS_W-1:0]       r_table [MAX_WALLS];
   logic [CW-1:0]          r_count;
   logic                   r_overflow;
   logic [POS_W-1:0]       r_pos;
   logic [BW-1:0]          r_base;
   logic                   r_collision;
   logic [IW-1:0]          r_hit_idx;

   logic                   w_full, w_wr_ready, w_wr_fire, w_accept, w_last_group;
   logic [LANES*POS_W-1:0] w_entries;
   logic [LANES-1:0]       w_valid;
   logic                   w_any_hit;
   logic [LIW-1:0]         w_lane_idx;

   assign w_full       = (r_count == CW'(MAX_WALLS));
   assign w_wr_ready   = (r_state == IDLE) && !w_full && !clear;
   assign w_wr_fire    = wr_en && w_wr_ready;
   assign w_accept     = (r_state == IDLE) && chk_req && !clear;
   assign w_last_group = (CMPW'(r_base) + CMPW'(LANES)) >= CMPW'(r_count);

   // Slots at or beyond wall_count are masked so stale RAM contents never match.
   always_comb begin
      logic [BW-1:0] v_idx;
      w_entries = '0;
      w_valid   = '0;
      for (int l = 0; l < LANES; l++) begin
         v_idx = r_base + BW'(l);
         if (CMPW'(v_idx) < CMPW'(r_count)) begin
            w_valid[l]                   = 1'b1;
            w_entries[l*POS_W +: POS_W]  = r_table[v_idx[IW-1:0]];
         end
      end
   end

   wall_match_group #(
      .POS_W (POS_W),
      .LANES (LANES)
   ) u_group (
      .i_key      (r_pos),
      .i_entries  (w_entries),
      .i_valid    (w_valid),
      .o_any_hit  (w_any_hit),
      .o_lane_idx (w_lane_idx)
   );

   always_ff @(posedge clk) begin
      if (!nrst) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      chk_done = 1'b0;
      case (r_state)
         IDLE: if (w_accept) w_next = SCAN;
         SCAN: if (w_any_hit || w_last_group) w_next = DONE;
         DONE: begin
            chk_done = !clear;
            w_next   = IDLE;
         end
         default: w_next = IDLE;
      endcase
      if (clear) w_next = IDLE;
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         r_count     <= '0;
         r_overflow  <= 1'b0;
         r_base      <= '0;
         r_collision <= 1'b0;
         r_hit_idx   <= '0;
      end else if (clear) begin
         r_count     <= '0;
         r_overflow  <= 1'b0;
         r_base      <= '0;
         r_collision <= 1'b0;
         r_hit_idx   <= '0;
      end else begin
         if (w_wr_fire)  r_count    <= r_count + CW'(1);
         else if (wr_en) r_overflow <= 1'b1;

         if (w_accept) begin
            r_base      <= '0;
            r_collision <= 1'b0;
            r_hit_idx   <= '0;
         end else if (r_state == SCAN) begin
            if (w_any_hit) begin
               r_collision <= 1'b1;
               r_hit_idx   <= IW'(r_base + BW'(w_lane_idx));
            end else if (!w_last_group) begin
               r_base <= r_base + BW'(LANES);
            end
         end
      end
   end

   // Table contents and the query key are plain data; validity comes from r_count.
   always_ff @(posedge clk) begin
      if (w_wr_fire) r_table[r_count[IW-1:0]] <= wr_pos;
      if (w_accept)  r_pos <= chk_pos;
   end

   assign wr_ready    = w_wr_ready;
   assign wall_count  = r_count;
   assign table_full  = w_full;
   assign wr_overflow = r_overflow;
   assign chk_busy    = (r_state != IDLE);
   assign collision   = r_collision;
   assign hit_index   = r_hit_idx;

endmodule
